// File: rtl/josh_pkg.sv
// Shared definitions for the game rendering path.
// Holds the screen geometry, the colour palette, and the frame_painter
// state encoding so every block agrees on them.
package josh_pkg;

  localparam int SCR_W   = 160;
  localparam int SCR_H   = 120;
  localparam int DUDE_SZ = 4;
  localparam int OBS_W   = 8;
  localparam int BAND_H  = 4;
  localparam int NUM_OBS = 4;

  // Colours are {R,G,B} for the 3-bit VGA adapter.
  localparam logic [2:0] COL_BG   = 3'b000;
  localparam logic [2:0] COL_BAND = 3'b111;
  localparam logic [2:0] COL_OBS  = 3'b100;
  localparam logic [2:0] COL_DUDE = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } painter_state_t;

endpackage

// File: rtl/pixel_shader.sv
// pixel_shader: purely combinational colour lookup for one pixel.
// Ports:
//   i_x, i_y            pixel column / row being classified
//   i_dude_x, i_dude_y  dude top-left corner (snapshot)
//   i_obs_x/h/top       packed obstacle list (snapshot), slot i at [8i+:8]/[7i+:7]/[i]
//   o_colour            colour after priority dude > obstacle > band > background
//   o_dude_hit          pixel lies inside the dude square
//   o_obs_hit           pixel lies inside any drawn obstacle (obs_h != 0)
module pixel_shader #(
  parameter int SCR_H   = josh_pkg::SCR_H,
  parameter int DUDE_SZ = josh_pkg::DUDE_SZ,
  parameter int OBS_W   = josh_pkg::OBS_W,
  parameter int BAND_H  = josh_pkg::BAND_H,
  parameter int NUM_OBS = josh_pkg::NUM_OBS
) (
  input  logic [7:0]           i_x,
  input  logic [6:0]           i_y,
  input  logic [7:0]           i_dude_x,
  input  logic [6:0]           i_dude_y,
  input  logic [8*NUM_OBS-1:0] i_obs_x,
  input  logic [7*NUM_OBS-1:0] i_obs_h,
  input  logic [NUM_OBS-1:0]   i_obs_top,
  output logic [2:0]           o_colour,
  output logic                 o_dude_hit,
  output logic                 o_obs_hit
);
  import josh_pkg::*;

  // Right/bottom extents are one bit wider than the operands so a shape
  // near the screen edge never wraps back to column/row 0.
  localparam logic [8:0] DUDE_EXT_X = 9'(DUDE_SZ - 1);
  localparam logic [7:0] DUDE_EXT_Y = 8'(DUDE_SZ - 1);
  localparam logic [8:0] OBS_EXT    = 9'(OBS_W - 1);
  localparam logic [6:0] H_MAX      = 7'(SCR_H);
  localparam logic [7:0] Y_END      = 8'(SCR_H);
  localparam logic [6:0] BAND_LO    = 7'(BAND_H);
  localparam logic [6:0] BAND_HI    = 7'(SCR_H - BAND_H);

  logic [8:0]         w_dude_r;
  logic [7:0]         w_dude_b;
  logic               w_in_dude;
  logic               w_in_band;
  logic [NUM_OBS-1:0] w_obs_slot;

  assign w_dude_r  = {1'b0, i_dude_x} + DUDE_EXT_X;
  assign w_dude_b  = {1'b0, i_dude_y} + DUDE_EXT_Y;
  assign w_in_dude = (i_x >= i_dude_x) && ({1'b0, i_x} <= w_dude_r) &&
                     (i_y >= i_dude_y) && ({1'b0, i_y} <= w_dude_b);

  for (genvar g = 0; g < NUM_OBS; g++) begin : g_obs
    logic [7:0] w_ox;
    logic [6:0] w_oh_raw;
    logic [6:0] w_oh;
    logic [8:0] w_or;
    logic       w_in_x;
    logic       w_in_y;

    assign w_ox     = i_obs_x[8*g +: 8];
    assign w_oh_raw = i_obs_h[7*g +: 7];
    // Heights taller than the screen behave as a full-height column.
    assign w_oh     = (w_oh_raw > H_MAX) ? H_MAX : w_oh_raw;
    assign w_or     = {1'b0, w_ox} + OBS_EXT;
    assign w_in_x   = (i_x >= w_ox) && ({1'b0, i_x} <= w_or);
    // Floor obstacles start at row SCR_H-h; h is clamped so this cannot underflow.
    assign w_in_y   = i_obs_top[g] ? (i_y < w_oh)
                                   : ({1'b0, i_y} >= (Y_END - {1'b0, w_oh}));
    assign w_obs_slot[g] = (w_oh != 7'd0) && w_in_x && w_in_y;
  end

  assign w_in_band  = (i_y < BAND_LO) || (i_y >= BAND_HI);
  assign o_dude_hit = w_in_dude;
  assign o_obs_hit  = |w_obs_slot;

  always_comb begin
    o_colour = COL_BG;
    if (w_in_dude)
      o_colour = COL_DUDE;
    else if (|w_obs_slot)
      o_colour = COL_OBS;
    else if (w_in_band)
      o_colour = COL_BAND;
  end

endmodule

// File: rtl/frame_painter.sv
// frame_painter: raster renderer feeding the 160x120 3-bit VGA adapter.
// On an accepted start it snapshots the dude/obstacle positions, sweeps
// every pixel in raster order (x fast), emits one registered VGA write per
// pixel and flags any dude/obstacle overlap on collide.
// Ports:
//   clk, resetn            clock, synchronous active-low reset
//   start                  frame request, only honoured in IDLE
//   dude_x, dude_y         dude top-left corner
//   obs_x, obs_h, obs_top  packed obstacle list
//   busy                   high from acceptance until back in IDLE
//   done                   one-cycle pulse when the frame is complete
//   collide                sticky overlap flag for the last frame
//   vga_x, vga_y, vga_colour, vga_plot   registered pixel write
//   dbg_state              current FSM state
module frame_painter #(
  parameter int SCR_W   = josh_pkg::SCR_W,
  parameter int SCR_H   = josh_pkg::SCR_H,
  parameter int DUDE_SZ = josh_pkg::DUDE_SZ,
  parameter int OBS_W   = josh_pkg::OBS_W,
  parameter int BAND_H  = josh_pkg::BAND_H,
  parameter int NUM_OBS = josh_pkg::NUM_OBS
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     start,
  input  logic [7:0]               dude_x,
  input  logic [6:0]               dude_y,
  input  logic [8*NUM_OBS-1:0]     obs_x,
  input  logic [7*NUM_OBS-1:0]     obs_h,
  input  logic [NUM_OBS-1:0]       obs_top,
  output logic                     busy,
  output logic                     done,
  output logic                     collide,
  output logic [7:0]               vga_x,
  output logic [6:0]               vga_y,
  output logic [2:0]               vga_colour,
  output logic                     vga_plot,
  output josh_pkg::painter_state_t dbg_state
);
  import josh_pkg::*;

  localparam logic [7:0] X_LAST = 8'(SCR_W - 1);
  localparam logic [6:0] Y_LAST = 7'(SCR_H - 1);

  painter_state_t       r_state;
  painter_state_t       w_next;

  logic [7:0]           r_x;
  logic [6:0]           r_y;
  logic [7:0]           r_dude_x;
  logic [6:0]           r_dude_y;
  logic [8*NUM_OBS-1:0] r_obs_x;
  logic [7*NUM_OBS-1:0] r_obs_h;
  logic [NUM_OBS-1:0]   r_obs_top;

  logic [7:0]           r_vga_x;
  logic [6:0]           r_vga_y;
  logic [2:0]           r_vga_colour;
  logic                 r_vga_plot;
  logic                 r_collide;

  logic                 w_accept;
  logic                 w_last;
  logic                 w_sweep;
  logic [2:0]           w_colour;
  logic                 w_dude_hit;
  logic                 w_obs_hit;

  assign w_accept = (r_state == ST_IDLE) && start;
  assign w_sweep  = (r_state == ST_SWEEP);
  assign w_last   = (r_x == X_LAST) && (r_y == Y_LAST);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!resetn)
      r_state <= ST_IDLE;
    else
      r_state <= w_next;
  end

  // FSM next state and status outputs. FLUSH exists so the last pixel,
  // which is still in the output register, is emitted before done.
  always_comb begin
    w_next = r_state;
    busy   = 1'b1;
    done   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) w_next = ST_SWEEP;
      end
      ST_SWEEP: if (w_last) w_next = ST_FLUSH;
      ST_FLUSH: w_next = ST_DONE;
      ST_DONE: begin
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Pixel counters and the position snapshot taken at acceptance.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_x       <= '0;
      r_y       <= '0;
      r_dude_x  <= '0;
      r_dude_y  <= '0;
      r_obs_x   <= '0;
      r_obs_h   <= '0;
      r_obs_top <= '0;
    end else if (w_accept) begin
      r_x       <= '0;
      r_y       <= '0;
      r_dude_x  <= dude_x;
      r_dude_y  <= dude_y;
      r_obs_x   <= obs_x;
      r_obs_h   <= obs_h;
      r_obs_top <= obs_top;
    end else if (w_sweep) begin
      if (r_x == X_LAST) begin
        r_x <= '0;
        r_y <= (r_y == Y_LAST) ? 7'd0 : r_y + 7'd1;
      end else begin
        r_x <= r_x + 8'd1;
      end
    end
  end

  pixel_shader #(
    .SCR_H   (SCR_H),
    .DUDE_SZ (DUDE_SZ),
    .OBS_W   (OBS_W),
    .BAND_H  (BAND_H),
    .NUM_OBS (NUM_OBS)
  ) u_shader (
    .i_x        (r_x),
    .i_y        (r_y),
    .i_dude_x   (r_dude_x),
    .i_dude_y   (r_dude_y),
    .i_obs_x    (r_obs_x),
    .i_obs_h    (r_obs_h),
    .i_obs_top  (r_obs_top),
    .o_colour   (w_colour),
    .o_dude_hit (w_dude_hit),
    .o_obs_hit  (w_obs_hit)
  );

  // Output register: one write per swept pixel, one cycle behind the
  // counters. collide is updated alongside the pixel that caused it.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_vga_x      <= '0;
      r_vga_y      <= '0;
      r_vga_colour <= '0;
      r_vga_plot   <= 1'b0;
      r_collide    <= 1'b0;
    end else begin
      r_vga_plot <= w_sweep;
      if (w_sweep) begin
        r_vga_x      <= r_x;
        r_vga_y      <= r_y;
        r_vga_colour <= w_colour;
      end
      if (w_accept)
        r_collide <= 1'b0;
      else if (w_sweep && w_dude_hit && w_obs_hit)
        r_collide <= 1'b1;
    end
  end

  assign vga_x      = r_vga_x;
  assign vga_y      = r_vga_y;
  assign vga_colour = r_vga_colour;
  assign vga_plot   = r_vga_plot;
  assign collide    = r_collide;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_frame_painter.sv
`timescale 1ns/1ps
module tb_frame_painter;
  import josh_pkg::*;

  localparam int W    = 160;
  localparam int H    = 120;
  localparam int NPIX = W * H;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  dude_x = '0;
  logic [6:0]  dude_y = '0;
  logic [31:0] obs_x = '0;
  logic [27:0] obs_h = '0;
  logic [3:0]  obs_top = '0;
  logic        busy, done, collide, vga_plot;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  painter_state_t dbg_state;

  frame_painter dut (
    .clk(clk), .resetn(resetn), .start(start),
    .dude_x(dude_x), .dude_y(dude_y),
    .obs_x(obs_x), .obs_h(obs_h), .obs_top(obs_top),
    .busy(busy), .done(done), .collide(collide),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  logic [2:0] fb [0:NPIX-1];
  int plot_cnt, order_err, oob_cnt, done_cnt, done_cyc, busy_cnt;
  int n_green, n_red, n_white, n_black, n_other;

  function automatic logic [2:0] px(input int x, input int y);
    return fb[y*W + x];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_obs(input int i, input logic [7:0] x, input logic [6:0] h, input logic t);
    obs_x[8*i +: 8] = x;
    obs_h[7*i +: 7] = h;
    obs_top[i]      = t;
  endtask

  // Pulses start, then collects every plotted pixel until one cycle past done.
  // At perturb_at the dude moves and a stray start is driven for one cycle.
  task automatic run_frame(input int perturb_at);
    int cyc;
    for (int i = 0; i < NPIX; i++) fb[i] = 3'b101;
    plot_cnt = 0; order_err = 0; oob_cnt = 0; done_cnt = 0; done_cyc = -1; busy_cnt = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    checks++;
    if (busy !== 1'b1 || collide !== 1'b0) begin
      errors++;
      $display("FAIL accept: busy=%b collide=%b, required busy=1 collide=0", busy, collide);
    end
    for (cyc = 0; cyc < 19400; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (vga_plot) begin
        if (vga_x >= 8'(W) || vga_y >= 7'(H)) oob_cnt++;
        else fb[int'(vga_y)*W + int'(vga_x)] = vga_colour;
        if (int'(vga_x) != plot_cnt % W || int'(vga_y) != plot_cnt / W) order_err++;
        plot_cnt++;
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) break;
      if (cyc == perturb_at) begin
        dude_x = dude_x + 8'd70;
        start  = 1'b1;
      end else if (cyc == perturb_at + 1) begin
        start = 1'b0;
      end
    end
    checks++;
    if (done_cyc < 0) begin
      errors++;
      $display("FAIL frame_timeout: no done within 19400 cycles");
    end
  endtask

  task automatic count_colours();
    n_green = 0; n_red = 0; n_white = 0; n_black = 0; n_other = 0;
    for (int i = 0; i < NPIX; i++) begin
      case (fb[i])
        3'b010:  n_green++;
        3'b100:  n_red++;
        3'b111:  n_white++;
        3'b000:  n_black++;
        default: n_other++;
      endcase
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, collide, vga_plot} !== 4'b0000 || vga_x !== 8'd0 ||
        vga_y !== 7'd0 || vga_colour !== 3'd0 || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b collide=%b plot=%b x=%0d y=%0d col=%b st=%0d, required all 0",
               busy, done, collide, vga_plot, vga_x, vga_y, vga_colour, dbg_state);
    end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_empty_snapshot();
    obs_h = '0; obs_x = '0; obs_top = '0;
    dude_x = 8'd10; dude_y = 7'd50;
    run_frame(5000);
    count_colours();
    checks++; if (plot_cnt !== 19200) begin errors++; $display("FAIL empty_plots: got %0d expected 19200", plot_cnt); end
    checks++; if (order_err !== 0) begin errors++; $display("FAIL empty_order: got %0d bad expected 0", order_err); end
    checks++; if (done_cyc !== 19201) begin errors++; $display("FAIL empty_done_cycle: got %0d expected 19201", done_cyc); end
    checks++; if (busy_cnt !== 19202) begin errors++; $display("FAIL empty_busy_cycles: got %0d expected 19202", busy_cnt); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL empty_done_count: got %0d expected 1", done_cnt); end
    checks++; if (collide !== 1'b0) begin errors++; $display("FAIL empty_collide: got %b expected 0", collide); end
    checks++;
    if (n_green !== 16 || n_white !== 1280 || n_black !== 17904 || n_red !== 0 || n_other !== 0) begin
      errors++;
      $display("FAIL empty_counts: g=%0d w=%0d b=%0d r=%0d o=%0d expected 16/1280/17904/0/0",
               n_green, n_white, n_black, n_red, n_other);
    end
    checks++; if (px(10,50) !== 3'b010) begin errors++; $display("FAIL empty_dude_tl: got %b expected 010", px(10,50)); end
    checks++; if (px(13,53) !== 3'b010) begin errors++; $display("FAIL empty_dude_br: got %b expected 010", px(13,53)); end
    checks++; if (px(14,53) !== 3'b000) begin errors++; $display("FAIL empty_dude_edge: got %b expected 000", px(14,53)); end
    checks++; if (px(80,50) !== 3'b000) begin errors++; $display("FAIL snapshot_moved_dude: got %b expected 000", px(80,50)); end
    checks++; if (px(0,3) !== 3'b111) begin errors++; $display("FAIL band_top_last: got %b expected 111", px(0,3)); end
    checks++; if (px(0,4) !== 3'b000) begin errors++; $display("FAIL band_top_after: got %b expected 000", px(0,4)); end
    checks++; if (px(159,116) !== 3'b111) begin errors++; $display("FAIL band_bot_first: got %b expected 111", px(159,116)); end
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done_cnt !== 1) begin
      errors++;
      $display("FAIL stray_start_queued: busy=%b done_cnt=%0d expected 0/1", busy, done_cnt);
    end
    dude_x = 8'd10;
  endtask

  task automatic test_floor_clip();
    obs_h = '0;
    set_obs(0, 8'd60, 7'd20, 1'b0);
    set_obs(1, 8'd156, 7'd10, 1'b1);
    set_obs(2, 8'd20, 7'd127, 1'b1);
    dude_x = 8'd158; dude_y = 7'd118;
    run_frame(-10);
    count_colours();
    checks++; if (plot_cnt !== 19200 || oob_cnt !== 0) begin errors++; $display("FAIL clip_plots: got %0d plots %0d oob expected 19200/0", plot_cnt, oob_cnt); end
    checks++; if (order_err !== 0) begin errors++; $display("FAIL clip_order: got %0d bad expected 0", order_err); end
    checks++; if (collide !== 1'b0) begin errors++; $display("FAIL floor_collide: got %b expected 0", collide); end
    checks++;
    if (n_red !== 1160 || n_green !== 4 || n_white !== 1164 || n_black !== 16872 || n_other !== 0) begin
      errors++;
      $display("FAIL floor_counts: r=%0d g=%0d w=%0d b=%0d o=%0d expected 1160/4/1164/16872/0",
               n_red, n_green, n_white, n_black, n_other);
    end
    checks++; if (px(60,100) !== 3'b100) begin errors++; $display("FAIL floor_tl: got %b expected 100", px(60,100)); end
    checks++; if (px(67,119) !== 3'b100) begin errors++; $display("FAIL floor_over_band: got %b expected 100", px(67,119)); end
    checks++; if (px(68,119) !== 3'b111) begin errors++; $display("FAIL floor_right_edge: got %b expected 111", px(68,119)); end
    checks++; if (px(59,100) !== 3'b000) begin errors++; $display("FAIL floor_left_edge: got %b expected 000", px(59,100)); end
    checks++; if (px(60,99) !== 3'b000) begin errors++; $display("FAIL floor_top_edge: got %b expected 000", px(60,99)); end
    checks++; if (px(156,0) !== 3'b100) begin errors++; $display("FAIL clip_obs_tl: got %b expected 100", px(156,0)); end
    checks++; if (px(159,9) !== 3'b100) begin errors++; $display("FAIL clip_obs_br: got %b expected 100", px(159,9)); end
    checks++; if (px(159,10) !== 3'b000) begin errors++; $display("FAIL clip_obs_below: got %b expected 000", px(159,10)); end
    checks++; if (px(155,0) !== 3'b111) begin errors++; $display("FAIL clip_obs_left: got %b expected 111", px(155,0)); end
    checks++; if (px(158,118) !== 3'b010) begin errors++; $display("FAIL clip_dude: got %b expected 010", px(158,118)); end
    checks++; if (px(157,118) !== 3'b111) begin errors++; $display("FAIL clip_dude_left: got %b expected 111", px(157,118)); end
    checks++; if (px(20,119) !== 3'b100 || px(27,60) !== 3'b100) begin errors++; $display("FAIL tall_obs_clamp: got %b/%b expected 100/100", px(20,119), px(27,60)); end
  endtask

  task automatic test_reset_midframe();
    int cyc;
    int dn;
    obs_h = '0;
    set_obs(2, 8'd0, 7'd60, 1'b1);
    dude_x = 8'd2; dude_y = 7'd2;
    dn = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (cyc = 0; cyc < 8000; cyc++) begin
      @(negedge clk);
      if (done) dn++;
    end
    checks++;
    if (collide !== 1'b1) begin errors++; $display("FAIL midframe_collide_set: got %b expected 1", collide); end
    resetn = 1'b0;
    @(negedge clk);
    checks++;
    if (vga_plot !== 1'b0 || busy !== 1'b0 || collide !== 1'b0) begin
      errors++;
      $display("FAIL midframe_abort: plot=%b busy=%b collide=%b expected 0/0/0", vga_plot, busy, collide);
    end
    @(negedge clk);
    resetn = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (done) dn++;
    end
    checks++;
    if (dn !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midframe_no_done: done_cnt=%0d busy=%b expected 0/0", dn, busy);
    end
  endtask

  task automatic test_collision();
    obs_h = '0;
    set_obs(0, 8'd60, 7'd20, 1'b0);
    dude_x = 8'd62; dude_y = 7'd98;
    run_frame(-10);
    count_colours();
    checks++; if (plot_cnt !== 19200 || done_cyc !== 19201) begin errors++; $display("FAIL fresh_frame: got %0d plots done at %0d expected 19200/19201", plot_cnt, done_cyc); end
    checks++; if (collide !== 1'b1) begin errors++; $display("FAIL collide_at_done: got %b expected 1", collide); end
    checks++;
    if (n_red !== 152 || n_green !== 16 || n_white !== 1248 || n_other !== 0) begin
      errors++;
      $display("FAIL collide_counts: r=%0d g=%0d w=%0d o=%0d expected 152/16/1248/0", n_red, n_green, n_white, n_other);
    end
    checks++; if (px(62,98) !== 3'b010) begin errors++; $display("FAIL collide_dude_tl: got %b expected 010", px(62,98)); end
    checks++; if (px(65,101) !== 3'b010) begin errors++; $display("FAIL collide_dude_over_obs: got %b expected 010", px(65,101)); end
    checks++; if (px(66,100) !== 3'b100) begin errors++; $display("FAIL collide_obs_beside: got %b expected 100", px(66,100)); end
    checks++; if (px(61,99) !== 3'b000) begin errors++; $display("FAIL collide_above_obs: got %b expected 000", px(61,99)); end
    checks++; if (px(62,102) !== 3'b100) begin errors++; $display("FAIL collide_obs_below: got %b expected 100", px(62,102)); end
    repeat (5) @(negedge clk);
    checks++; if (collide !== 1'b1) begin errors++; $display("FAIL collide_hold: got %b expected 1", collide); end
  endtask

  task automatic test_collide_clear();
    obs_h = '0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    checks++;
    if (collide !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL collide_clear_on_start: collide=%b busy=%b expected 0/1", collide, busy);
    end
    repeat (20) @(negedge clk);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_empty_snapshot();
    test_floor_clip();
    test_reset_midframe();
    test_collision();
    test_collide_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
